// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding / hazard unit.
// Operand mux selects and stall observer FSM states.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b10;
  localparam logic [1:0] FWD_MWB = 2'b01;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } st_e;

endpackage

// File: rtl/fwd_scoreboard.sv
// Pending-register scoreboard for long-latency ops.
// Completion writes through the register file, so a same-cycle done clears RAW.
module fwd_scoreboard #(
  parameter int REG_AW      = 2,
  parameter int NUM_SRC     = 2,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_issue,
  input  logic [REG_AW-1:0]         i_issue_dest,
  input  logic                      i_done,
  input  logic [REG_AW-1:0]         i_done_dest,
  input  logic                      i_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] i_id_src,
  input  logic [NUM_SRC-1:0]        i_id_used,
  input  logic                      i_id_wr,
  input  logic [REG_AW-1:0]         i_id_dest,
  output logic                      o_hazard,
  output logic [2**REG_AW-1:0]      o_pend
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0]   r_pend;
  logic [NREG-1:0]   w_pend_nxt;
  logic [REG_AW-1:0] w_a;
  logic              w_raw;
  logic              w_waw;

  function automatic logic f_exempt(input logic [REG_AW-1:0] a);
    return (ZERO_REG_EN != 0) && (a == '0);
  endfunction

  // next pending set: done clears first, issue sets after so it wins
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_done)
      w_pend_nxt[i_done_dest] = 1'b0;
    if (i_issue)
      w_pend_nxt[i_issue_dest] = 1'b1;
  end

  // pending bit storage
  always_ff @(posedge clk) begin
    if (rst)
      r_pend <= '0;
    else
      r_pend <= w_pend_nxt;
  end

  // RAW on used sources (with done bypass) and WAW on destination
  always_comb begin
    w_raw = 1'b0;
    w_a   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_a = i_id_src[i*REG_AW +: REG_AW];
      if (i_id_used[i] && r_pend[w_a] &&
          !(i_done && (i_done_dest == w_a)) &&
          !f_exempt(w_a))
        w_raw = 1'b1;
    end
    w_waw = i_id_wr && r_pend[i_id_dest] &&
            !f_exempt(i_id_dest);
  end

  assign o_hazard = i_id_valid && (w_raw || w_waw);
  assign o_pend   = r_pend;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding, load-use / scoreboard stall control,
// stall observer FSM with watchdog and saturating stall counter.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW      = 2,
  parameter int NUM_SRC     = 2,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16,
  parameter int STALL_TMO   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_reg_write,
  input  logic [REG_AW-1:0]         id_reg_dest,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      ex_reg_write,
  input  logic [REG_AW-1:0]         ex_reg_dest,
  input  logic                      ex_is_load,
  input  logic                      exm_reg_write,
  input  logic [REG_AW-1:0]         exm_reg_dest,
  input  logic                      exm_is_load,
  input  logic                      mwb_reg_write,
  input  logic [REG_AW-1:0]         mwb_reg_dest,
  input  logic                      lo_issue,
  input  logic [REG_AW-1:0]         lo_dest,
  input  logic                      lo_done,
  input  logic [REG_AW-1:0]         lo_done_dest,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [2**REG_AW-1:0]      sb_pend,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      stall_timeout
);

  localparam int CW = (STALL_TMO < 2) ? 1 : $clog2(STALL_TMO + 1);
  localparam logic [CW-1:0] TMO_M1 = CW'(STALL_TMO - 1);
  localparam logic [CW-1:0] TMO    = CW'(STALL_TMO);

  logic              w_lu;
  logic              w_sb;
  logic              w_stall;
  logic [REG_AW-1:0] w_ida;
  st_e               r_state;
  st_e               w_state_nxt;
  logic              w_cons_inc;
  logic              w_tmo_hit;
  logic [CW-1:0]     r_cons;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_timeout;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    logic [REG_AW-1:0] w_src;
    logic              w_zero;
    logic              w_exm;
    logic              w_mwb;
    logic [1:0]        w_sel;
    assign w_src  = ex_src[g*REG_AW +: REG_AW];
    assign w_zero = (ZERO_REG_EN != 0) && (w_src == '0);
    assign w_exm  = exm_reg_write && !exm_is_load &&
                    (exm_reg_dest == w_src);
    assign w_mwb  = mwb_reg_write && (mwb_reg_dest == w_src);
    assign w_sel  = (!ex_valid || w_zero) ? FWD_RF  :
                    w_exm                 ? FWD_EXM :
                    w_mwb                 ? FWD_MWB : FWD_RF;
    assign fwd_sel[2*g +: 2] = w_sel;
  end

  // load-use: a used ID source matches the destination of a load in EX
  always_comb begin
    w_lu  = 1'b0;
    w_ida = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ida = id_src[i*REG_AW +: REG_AW];
      if (id_src_used[i] && (w_ida == ex_reg_dest) &&
          !((ZERO_REG_EN != 0) && (w_ida == '0)))
        w_lu = 1'b1;
    end
    w_lu = w_lu && id_valid && ex_valid &&
           ex_is_load && ex_reg_write;
  end

  fwd_scoreboard #(
    .REG_AW      (REG_AW),
    .NUM_SRC     (NUM_SRC),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (lo_issue),
    .i_issue_dest (lo_dest),
    .i_done       (lo_done),
    .i_done_dest  (lo_done_dest),
    .i_id_valid   (id_valid),
    .i_id_src     (id_src),
    .i_id_used    (id_src_used),
    .i_id_wr      (id_reg_write),
    .i_id_dest    (id_reg_dest),
    .o_hazard     (w_sb),
    .o_pend       (sb_pend)
  );

  assign w_stall   = !rst && (w_lu || w_sb);
  assign stall_id  = w_stall;
  assign bubble_ex = w_stall;

  // observer FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= RUN;
    else
      r_state <= w_state_nxt;
  end

  // observer FSM next state follows the stall line
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_stall)  w_state_nxt = STALL;
      STALL:   if (!w_stall) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // observer FSM outputs: count this cycle, detect watchdog threshold
  always_comb begin
    w_cons_inc = (w_state_nxt == STALL);
    w_tmo_hit  = w_cons_inc && (r_cons >= TMO_M1);
  end

  // consecutive stall run length, saturating at the threshold
  always_ff @(posedge clk) begin
    if (rst)
      r_cons <= '0;
    else if (!w_cons_inc)
      r_cons <= '0;
    else if (r_cons != TMO)
      r_cons <= r_cons + 1'b1;
  end

  // sticky watchdog flag
  always_ff @(posedge clk) begin
    if (rst)
      r_timeout <= 1'b0;
    else if (w_tmo_hit)
      r_timeout <= 1'b1;
  end

  // total stall cycles, saturating at all ones
  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench: dut0 (ZERO_REG_EN=0, CNT_W=3, STALL_TMO=4)
// and dut1 (ZERO_REG_EN=1, defaults) share all stimulus.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src;
  logic [1:0] id_src_used;
  logic       id_reg_write;
  logic [1:0] id_reg_dest;
  logic       ex_valid;
  logic [3:0] ex_src;
  logic       ex_reg_write;
  logic [1:0] ex_reg_dest;
  logic       ex_is_load;
  logic       exm_reg_write;
  logic [1:0] exm_reg_dest;
  logic       exm_is_load;
  logic       mwb_reg_write;
  logic [1:0] mwb_reg_dest;
  logic       lo_issue;
  logic [1:0] lo_dest;
  logic       lo_done;
  logic [1:0] lo_done_dest;

  logic [3:0]  d0_fwd, d1_fwd;
  logic        d0_stall, d1_stall;
  logic        d0_bub, d1_bub;
  logic [3:0]  d0_pend, d1_pend;
  logic [2:0]  d0_cnt;
  logic [15:0] d1_cnt;
  logic        d0_tmo, d1_tmo;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_AW(2), .NUM_SRC(2), .ZERO_REG_EN(0),
    .CNT_W(3), .STALL_TMO(4)
  ) dut0 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used),
    .id_reg_write(id_reg_write), .id_reg_dest(id_reg_dest),
    .ex_valid(ex_valid), .ex_src(ex_src),
    .ex_reg_write(ex_reg_write), .ex_reg_dest(ex_reg_dest),
    .ex_is_load(ex_is_load),
    .exm_reg_write(exm_reg_write), .exm_reg_dest(exm_reg_dest),
    .exm_is_load(exm_is_load),
    .mwb_reg_write(mwb_reg_write), .mwb_reg_dest(mwb_reg_dest),
    .lo_issue(lo_issue), .lo_dest(lo_dest),
    .lo_done(lo_done), .lo_done_dest(lo_done_dest),
    .fwd_sel(d0_fwd), .stall_id(d0_stall), .bubble_ex(d0_bub),
    .sb_pend(d0_pend), .stall_cnt(d0_cnt),
    .stall_timeout(d0_tmo)
  );

  fwd_hazard_ctrl #(
    .REG_AW(2), .NUM_SRC(2), .ZERO_REG_EN(1),
    .CNT_W(16), .STALL_TMO(64)
  ) dut1 (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used),
    .id_reg_write(id_reg_write), .id_reg_dest(id_reg_dest),
    .ex_valid(ex_valid), .ex_src(ex_src),
    .ex_reg_write(ex_reg_write), .ex_reg_dest(ex_reg_dest),
    .ex_is_load(ex_is_load),
    .exm_reg_write(exm_reg_write), .exm_reg_dest(exm_reg_dest),
    .exm_is_load(exm_is_load),
    .mwb_reg_write(mwb_reg_write), .mwb_reg_dest(mwb_reg_dest),
    .lo_issue(lo_issue), .lo_dest(lo_dest),
    .lo_done(lo_done), .lo_done_dest(lo_done_dest),
    .fwd_sel(d1_fwd), .stall_id(d1_stall), .bubble_ex(d1_bub),
    .sb_pend(d1_pend), .stall_cnt(d1_cnt),
    .stall_timeout(d1_tmo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_src = 0; id_src_used = 0;
    id_reg_write = 0; id_reg_dest = 0;
    ex_valid = 0; ex_src = 0; ex_reg_write = 0;
    ex_reg_dest = 0; ex_is_load = 0;
    exm_reg_write = 0; exm_reg_dest = 0; exm_is_load = 0;
    mwb_reg_write = 0; mwb_reg_dest = 0;
    lo_issue = 0; lo_dest = 0; lo_done = 0; lo_done_dest = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    step();
    step();
    chk("rst_stall", d0_stall, 0);
    chk("rst_pend", d0_pend, 0);
    chk("rst_cnt", d0_cnt, 0);
    chk("rst_tmo", d0_tmo, 0);
    rst = 0;

    // forwarding priority
    ex_valid = 1; ex_src = 4'b0101;
    exm_reg_write = 1; exm_reg_dest = 1;
    mwb_reg_write = 1; mwb_reg_dest = 1;
    #1 chk("fwd_exm", d0_fwd, 4'b1010);
    exm_reg_write = 0;
    #1 chk("fwd_mwb", d0_fwd, 4'b0101);
    mwb_reg_write = 0;
    #1 chk("fwd_rf", d0_fwd, 4'b0000);
    exm_reg_write = 1; exm_is_load = 1; mwb_reg_write = 1;
    #1 chk("fwd_ld_skip", d0_fwd, 4'b0101);
    ex_valid = 0;
    #1 chk("fwd_ex_inv", d0_fwd, 4'b0000);
    clr();

    // load-use
    ex_valid = 1; ex_is_load = 1; ex_reg_write = 1;
    ex_reg_dest = 2;
    id_valid = 1; id_src = 4'b1000; id_src_used = 2'b01;
    #1 chk("lu_unused", d0_stall, 0);
    id_src_used = 2'b10;
    #1 chk("lu_stall", d0_stall, 1);
    chk("lu_bubble", d0_bub, 1);
    step();
    clr();
    ex_valid = 1; ex_src = 4'b1000;
    mwb_reg_write = 1; mwb_reg_dest = 2;
    #1 chk("lu_fwd", d0_fwd[3:2], 2'b01);
    chk("lu_release", d0_stall, 0);
    chk("lu_cnt", d0_cnt, 1);
    clr();

    // scoreboard with watchdog
    lo_issue = 1; lo_dest = 3;
    step();
    lo_issue = 0;
    #1 chk("sb_set", d0_pend, 4'b1000);
    id_valid = 1; id_src = 4'b0011; id_src_used = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      #1 chk("sb_hold", d0_stall, 1);
      step();
      chk("wd_tmo", d0_tmo, (k >= 4) ? 1 : 0);
    end
    lo_done = 1; lo_done_dest = 3;
    #1 chk("sb_bypass0", d0_stall, 0);
    chk("sb_bypass1", d1_stall, 0);
    step();
    lo_done = 0;
    #1 chk("sb_clr", d0_pend, 0);
    chk("sb_after", d0_stall, 0);
    chk("wd_sticky", d0_tmo, 1);
    chk("wd_d1", d1_tmo, 0);
    chk("sb_cnt0", d0_cnt, 5);
    chk("sb_cnt1", d1_cnt, 5);
    clr();

    // WAW
    lo_issue = 1; lo_dest = 1;
    step();
    lo_issue = 0;
    id_valid = 1; id_reg_write = 1; id_reg_dest = 1;
    #1 chk("waw", d0_stall, 1);
    id_valid = 0; lo_done = 1; lo_done_dest = 1;
    step();
    clr();
    #1 chk("waw_clr", d0_pend, 0);

    // same-cycle issue/done on r0
    lo_issue = 1; lo_dest = 0; lo_done = 1; lo_done_dest = 0;
    step();
    clr();
    #1 chk("z_pend", d0_pend, 4'b0001);
    id_valid = 1; id_src = 0; id_src_used = 2'b11;
    ex_valid = 1; ex_src = 0;
    mwb_reg_write = 1; mwb_reg_dest = 0;
    #1 chk("z0_stall", d0_stall, 1);
    chk("z1_stall", d1_stall, 0);
    chk("z0_fwd", d0_fwd, 4'b0101);
    chk("z1_fwd", d1_fwd, 4'b0000);
    id_valid = 0; lo_done = 1; lo_done_dest = 0;
    step();
    clr();
    #1 chk("z_clr", d0_pend, 0);

    // saturation then reset mid-stall
    lo_issue = 1; lo_dest = 2;
    step();
    lo_issue = 0;
    id_valid = 1; id_src = 4'b0010; id_src_used = 2'b01;
    repeat (6) step();
    chk("sat0", d0_cnt, 7);
    chk("sat1", d1_cnt, 11);
    chk("sat_stall", d0_stall, 1);
    rst = 1;
    #1 chk("rp_gate", d0_stall, 0);
    chk("rp_gate_b", d0_bub, 0);
    step();
    rst = 0;
    #1 chk("rp_pend", d0_pend, 0);
    chk("rp_cnt", d0_cnt, 0);
    chk("rp_cnt1", d1_cnt, 0);
    chk("rp_tmo", d0_tmo, 0);
    chk("rp_stall", d0_stall, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
